// File: rtl/wvb_rd_ctrl.sv
// -----------------------------------------------------------------------------
// wvb_rd_ctrl
//
// Waveform buffer read controller for one mDOM channel. Pops one event header
// from the header FIFO, presents the decoded header downstream, then reads the
// event's samples out of the waveform RAM and streams them over a valid/ready
// handshake. It also publishes the read pointer, which upstream overflow logic
// uses to decide how much buffer space is free.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   hdr_empty       header FIFO empty flag (FIFO has 1-cycle read latency)
//   hdr_rdreq       header FIFO pop, single-cycle pulse
//   hdr_data        header word: ltc | start_addr | stop_addr | trig_src |
//                   cnst_run | pre_conf (LSB first)
//   wvb_rd_addr     waveform RAM read address
//   wvb_rden        waveform RAM read enable (data returns one cycle later)
//   wvb_data        waveform RAM read data
//   evt_*           latched header fields of the current/last event
//   evt_len         sample count of the event (1 .. 2**P_ADR_WIDTH)
//   hdr_valid       evt_* valid; held until hdr_ready
//   hdr_ready       downstream accepts the header
//   dout            sample data
//   dout_valid      dout valid
//   dout_last       marks the final sample of the event
//   dout_ready      downstream accepts the sample
//   rd_ptr          address following the last sample accepted downstream
//   busy            controller is working on an event
//   evt_cnt         completed event count (wraps)
// -----------------------------------------------------------------------------
module wvb_rd_ctrl #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_LTC_WIDTH  = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hdr_empty,
    output logic                     hdr_rdreq,
    input  logic [P_HDR_WIDTH-1:0]   hdr_data,
    output logic [P_ADR_WIDTH-1:0]   wvb_rd_addr,
    output logic                     wvb_rden,
    input  logic [P_DATA_WIDTH-1:0]  wvb_data,
    output logic [P_LTC_WIDTH-1:0]   evt_ltc,
    output logic [P_ADR_WIDTH:0]     evt_len,
    output logic [1:0]               evt_trig_src,
    output logic                     evt_cnst_run,
    output logic [4:0]               evt_pre_conf,
    output logic                     hdr_valid,
    input  logic                     hdr_ready,
    output logic [P_DATA_WIDTH-1:0]  dout,
    output logic                     dout_valid,
    output logic                     dout_last,
    input  logic                     dout_ready,
    output logic [P_ADR_WIDTH-1:0]   rd_ptr,
    output logic                     busy,
    output logic [15:0]              evt_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HDR_WAIT = 2'd1;
    localparam logic [1:0] S_HDR      = 2'd2;
    localparam logic [1:0] S_DATA     = 2'd3;

    // Header word field offsets
    localparam int LO_START = P_LTC_WIDTH;
    localparam int LO_STOP  = P_LTC_WIDTH + P_ADR_WIDTH;
    localparam int LO_TRIG  = P_LTC_WIDTH + 2 * P_ADR_WIDTH;
    localparam int LO_CNST  = LO_TRIG + 2;
    localparam int LO_PRE   = LO_CNST + 1;

    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;
    localparam logic [P_ADR_WIDTH:0]   LEN_ONE = 1;

    logic [1:0]               state_reg, state_next;
    logic [P_ADR_WIDTH-1:0]   rd_addr_reg;
    logic [P_ADR_WIDTH-1:0]   out_addr_reg;
    logic [P_ADR_WIDTH-1:0]   rd_ptr_reg;
    logic [P_ADR_WIDTH:0]     rem_reg;
    logic [P_ADR_WIDTH:0]     evt_len_reg;
    logic [P_LTC_WIDTH-1:0]   evt_ltc_reg;
    logic [1:0]               evt_trig_src_reg;
    logic                     evt_cnst_run_reg;
    logic [4:0]               evt_pre_conf_reg;
    logic [15:0]              evt_cnt_reg;

    // Two-entry output buffer: buf0 is the output register, buf1 the skid.
    logic [P_DATA_WIDTH-1:0]  buf0_reg, buf1_reg;
    logic                     buf0_last_reg, buf1_last_reg;
    logic [1:0]               cnt_reg;
    // A read issued last cycle whose data is on wvb_data this cycle.
    logic                     inf_reg;
    logic                     inf_last_reg;

    logic [P_ADR_WIDTH-1:0]   hdr_start;
    logic [P_ADR_WIDTH-1:0]   hdr_stop;
    logic [P_ADR_WIDTH-1:0]   hdr_span;
    logic [P_ADR_WIDTH:0]     hdr_len;
    logic                     hdr_pop;
    logic                     out_valid;
    logic [P_DATA_WIDTH-1:0]  out_data;
    logic                     out_last;
    logic                     dout_hs;
    logic [1:0]               fill;
    logic                     rd_issue;

    assign hdr_start = hdr_data[LO_START +: P_ADR_WIDTH];
    assign hdr_stop  = hdr_data[LO_STOP  +: P_ADR_WIDTH];
    // Modular difference: stop below start means the event wraps the RAM.
    assign hdr_span  = hdr_stop - hdr_start;
    assign hdr_len   = {1'b0, hdr_span} + LEN_ONE;

    // Never pop while reset is held: the popped word would be lost.
    assign hdr_pop = (state_reg == S_IDLE) && !hdr_empty && !rst;

    // The oldest entry drives the output. When the buffer is empty the RAM
    // data is passed straight through so the first sample appears the cycle
    // after its read; if it is not accepted it is captured into buf0 and
    // keeps being presented unchanged.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (cnt_reg != 2'd0) begin
            out_valid = 1'b1;
            out_data  = buf0_reg;
            out_last  = buf0_last_reg;
        end else if (inf_reg) begin
            out_valid = 1'b1;
            out_data  = wvb_data;
            out_last  = inf_last_reg;
        end
    end

    assign dout_hs = out_valid && dout_ready;

    // Buffered plus in-flight samples never exceed two; a new read is allowed
    // at the limit only when a sample leaves in the same cycle.
    assign fill     = cnt_reg + {1'b0, inf_reg};
    assign rd_issue = (state_reg == S_DATA) && (rem_reg != '0) &&
                      ((fill < 2'd2) || ((fill == 2'd2) && dout_hs));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (hdr_pop) state_next = S_HDR_WAIT;
            S_HDR_WAIT: state_next = S_HDR;
            S_HDR:      if (hdr_ready) state_next = S_DATA;
            S_DATA:     if (dout_hs && out_last) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            rd_addr_reg      <= '0;
            out_addr_reg     <= '0;
            rd_ptr_reg       <= '0;
            rem_reg          <= '0;
            evt_len_reg      <= '0;
            evt_ltc_reg      <= '0;
            evt_trig_src_reg <= '0;
            evt_cnst_run_reg <= 1'b0;
            evt_pre_conf_reg <= '0;
            evt_cnt_reg      <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == S_HDR_WAIT) begin
                evt_ltc_reg      <= hdr_data[P_LTC_WIDTH-1:0];
                evt_trig_src_reg <= hdr_data[LO_TRIG +: 2];
                evt_cnst_run_reg <= hdr_data[LO_CNST];
                evt_pre_conf_reg <= hdr_data[LO_PRE +: 5];
                evt_len_reg      <= hdr_len;
                rem_reg          <= hdr_len;
                rd_addr_reg      <= hdr_start;
                out_addr_reg     <= hdr_start;
            end else if (rd_issue) begin
                rd_addr_reg <= rd_addr_reg + ADR_ONE;
                rem_reg     <= rem_reg - LEN_ONE;
            end

            // out_addr_reg tracks the address of the sample at the output.
            if (dout_hs) begin
                out_addr_reg <= out_addr_reg + ADR_ONE;
                rd_ptr_reg   <= out_addr_reg + ADR_ONE;
                if (out_last) begin
                    evt_cnt_reg <= evt_cnt_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_reg      <= '0;
            buf1_reg      <= '0;
            buf0_last_reg <= 1'b0;
            buf1_last_reg <= 1'b0;
            cnt_reg       <= 2'd0;
            inf_reg       <= 1'b0;
            inf_last_reg  <= 1'b0;
        end else begin
            inf_reg      <= rd_issue;
            inf_last_reg <= rd_issue && (rem_reg == LEN_ONE);

            if (inf_reg) begin
                if (cnt_reg == 2'd0) begin
                    // Pass-through sample not taken: park it in buf0.
                    if (!dout_hs) begin
                        buf0_reg      <= wvb_data;
                        buf0_last_reg <= inf_last_reg;
                        cnt_reg       <= 2'd1;
                    end
                end else if (dout_hs) begin
                    // buf0 leaves, arriving sample replaces it.
                    buf0_reg      <= wvb_data;
                    buf0_last_reg <= inf_last_reg;
                end else begin
                    buf1_reg      <= wvb_data;
                    buf1_last_reg <= inf_last_reg;
                    cnt_reg       <= 2'd2;
                end
            end else if (dout_hs) begin
                buf0_reg      <= buf1_reg;
                buf0_last_reg <= buf1_last_reg;
                cnt_reg       <= cnt_reg - 2'd1;
            end
        end
    end

    assign hdr_rdreq    = hdr_pop;
    assign wvb_rden     = rd_issue;
    assign wvb_rd_addr  = rd_addr_reg;
    assign evt_ltc      = evt_ltc_reg;
    assign evt_len      = evt_len_reg;
    assign evt_trig_src = evt_trig_src_reg;
    assign evt_cnst_run = evt_cnst_run_reg;
    assign evt_pre_conf = evt_pre_conf_reg;
    assign hdr_valid    = (state_reg == S_HDR);
    assign dout         = out_data;
    assign dout_valid   = out_valid;
    assign dout_last    = out_last;
    assign rd_ptr       = rd_ptr_reg;
    assign busy         = (state_reg != S_IDLE);
    assign evt_cnt      = evt_cnt_reg;

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wvb_rd_ctrl
//
// Drives wvb_rd_ctrl with a header FIFO model and a registered-read RAM model.
// Expected sample streams are built from the header (start, stop) and RAM
// contents; every accepted sample is recorded and compared against them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wvb_rd_ctrl;

    localparam int DW = 22;
    localparam int AW = 12;
    localparam int HW = 80;
    localparam int LW = 48;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           hdr_empty;
    logic           hdr_rdreq;
    logic [HW-1:0]  hdr_data = '0;
    logic [AW-1:0]  wvb_rd_addr;
    logic           wvb_rden;
    logic [DW-1:0]  wvb_data = '0;
    logic [LW-1:0]  evt_ltc;
    logic [AW:0]    evt_len;
    logic [1:0]     evt_trig_src;
    logic           evt_cnst_run;
    logic [4:0]     evt_pre_conf;
    logic           hdr_valid;
    logic           hdr_ready = 1'b1;
    logic [DW-1:0]  dout;
    logic           dout_valid;
    logic           dout_last;
    logic           dout_ready = 1'b1;
    logic [AW-1:0]  rd_ptr;
    logic           busy;
    logic [15:0]    evt_cnt;

    always #5 clk = ~clk;

    wvb_rd_ctrl #(
        .P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW), .P_LTC_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq), .hdr_data(hdr_data),
        .wvb_rd_addr(wvb_rd_addr), .wvb_rden(wvb_rden), .wvb_data(wvb_data),
        .evt_ltc(evt_ltc), .evt_len(evt_len), .evt_trig_src(evt_trig_src),
        .evt_cnst_run(evt_cnst_run), .evt_pre_conf(evt_pre_conf),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .dout_ready(dout_ready),
        .rd_ptr(rd_ptr), .busy(busy), .evt_cnt(evt_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waveform RAM, registered read
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        if (wvb_rden) wvb_data <= ram[wvb_rd_addr];
    end

    // Header FIFO, 1-cycle read latency
    logic [HW-1:0] fifo_mem [0:15];
    logic [3:0]    fifo_wr = 4'd0;
    logic [3:0]    fifo_rd = 4'd0;
    assign hdr_empty = (fifo_wr == fifo_rd);
    always @(posedge clk) begin
        if (hdr_rdreq) begin
            hdr_data <= fifo_mem[fifo_rd];
            fifo_rd  <= fifo_rd + 4'd1;
        end
    end

    // Backpressure generators
    bit rdy_rand  = 1'b0;
    bit hrdy_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        dout_ready = rdy_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
        hdr_ready  = hrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: records accepted samples and checks the hold rule
    int          cyc = 0;
    logic [DW:0] got_q[$];
    logic [DW:0] exp_q[$];
    int          rdreq_cyc[$];
    int          last_cyc[$];
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_dout = '0;
    logic        prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", 160'(dout_valid), 160'(1));
                chk("hold_dout",  160'(dout), 160'(prev_dout));
                chk("hold_last",  160'(dout_last), 160'(prev_last));
            end
            if (hdr_rdreq) begin
                chk("rdreq_nonempty", 160'(hdr_empty), 160'(0));
                rdreq_cyc.push_back(cyc);
            end
            if (dout_valid && dout_ready) begin
                got_q.push_back({dout_last, dout});
                if (dout_last) last_cyc.push_back(cyc);
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: an event is the samples at start, start+1, ... stop (mod
    // RAM size), the final one flagged last.
    logic [LW-1:0] exp_ltc;
    logic [1:0]    exp_trig;
    logic          exp_cnst;
    logic [4:0]    exp_pre;
    logic [AW:0]   exp_len;

    task automatic push_hdr(input logic [AW-1:0] start, input logic [AW-1:0] stop, input int max_n);
        logic [63:0] r;
        int s, p, len;
        logic lst;
        r        = {$urandom, $urandom};
        exp_ltc  = r[LW-1:0];
        exp_trig = 2'($urandom);
        exp_cnst = 1'($urandom);
        exp_pre  = 5'($urandom);
        s   = int'(start);
        p   = int'(stop);
        len = ((p - s + 4096) % 4096) + 1;
        exp_len = 13'(len);
        fifo_mem[fifo_wr] = {exp_pre, exp_cnst, exp_trig, stop, start, exp_ltc};
        fifo_wr = fifo_wr + 4'd1;
        for (int i = 0; i < len && i < max_n; i++) begin
            lst = (i == len - 1);
            exp_q.push_back({lst, ram[(s + i) % 4096]});
        end
    endtask

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_count"}, 160'(got_q.size()), 160'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_sample"}, 160'(got_q[i]), 160'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_ltc"},  160'(evt_ltc), 160'(exp_ltc));
        chk({tag, "_len"},  160'(evt_len), 160'(exp_len));
        chk({tag, "_trig"}, 160'(evt_trig_src), 160'(exp_trig));
        chk({tag, "_cnst"}, 160'(evt_cnst_run), 160'(exp_cnst));
        chk({tag, "_pre"},  160'(evt_pre_conf), 160'(exp_pre));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        i = 0;
        while (evt_cnt != 16'(target) && i < budget) begin
            step();
            i++;
        end
        chk("done_wait", 160'(evt_cnt), 160'(target));
    endtask

    localparam int ALL = 1 << 30;

    initial begin
        logic [AW-1:0] st;
        int ln;
        for (int i = 0; i < 4096; i++) ram[i] = DW'(i);

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_outputs",
            160'({hdr_rdreq, wvb_rden, wvb_rd_addr, hdr_valid, dout, dout_valid,
                  dout_last, rd_ptr, busy, evt_cnt}), 160'(0));
        chk("reset_fields",
            160'({evt_ltc, evt_len, evt_trig_src, evt_cnst_run, evt_pre_conf}), 160'(0));

        // Single event 0x010..0x014, cycle-accurate latency
        push_hdr(12'h010, 12'h014, ALL);
        #1;
        chk("t1_rdreq", 160'(hdr_rdreq), 160'(1));
        step();
        chk("t1_wait_busy", 160'(busy), 160'(1));
        chk("t1_wait_rdreq", 160'(hdr_rdreq), 160'(0));
        chk("t1_wait_hvalid", 160'(hdr_valid), 160'(0));
        step();
        chk("t1_hvalid", 160'(hdr_valid), 160'(1));
        check_fields("t1");
        step();
        chk("t1_rden", 160'(wvb_rden), 160'(1));
        chk("t1_addr", 160'(wvb_rd_addr), 160'(12'h010));
        chk("t1_no_dout_yet", 160'(dout_valid), 160'(0));
        step();
        chk("t1_first_valid", 160'(dout_valid), 160'(1));
        chk("t1_first_dout", 160'(dout), 160'(22'h010));
        repeat (4) step();
        chk("t1_last_flag", 160'(dout_last), 160'(1));
        chk("t1_last_dout", 160'(dout), 160'(22'h014));
        step();
        chk("t1_idle", 160'(busy), 160'(0));
        chk("t1_evt_cnt", 160'(evt_cnt), 160'(1));
        chk("t1_rd_ptr", 160'(rd_ptr), 160'(12'h015));
        compare_stream("t1");

        // Wrap-around 0xFFE..0x001
        push_hdr(12'hFFE, 12'h001, ALL);
        wait_done(2, 100);
        chk("t2_len", 160'(evt_len), 160'(4));
        chk("t2_rd_ptr", 160'(rd_ptr), 160'(12'h002));
        compare_stream("t2");

        // Whole buffer: 4096 samples
        push_hdr(12'h100, 12'h0FF, ALL);
        wait_done(3, 5000);
        chk("t3_len", 160'(evt_len), 160'(4096));
        chk("t3_rd_ptr", 160'(rd_ptr), 160'(12'h100));
        compare_stream("t3");

        // Random data, random backpressure on both handshakes, 3 events
        for (int i = 0; i < 4096; i++) ram[i] = DW'($urandom);
        rdy_rand  = 1'b1;
        hrdy_rand = 1'b1;
        for (int e = 0; e < 3; e++) begin
            st = AW'($urandom);
            ln = $urandom_range(1, 48);
            push_hdr(st, st + AW'(ln - 1), ALL);
        end
        wait_done(6, 3000);
        check_fields("t4");
        chk("t4_rd_ptr", 160'(rd_ptr), 160'(st + AW'(ln)));
        compare_stream("t4");
        rdy_rand  = 1'b0;
        hrdy_rand = 1'b0;
        step();

        // Back-to-back headers, lengths 3 and 1
        rdreq_cyc.delete();
        last_cyc.delete();
        st = AW'($urandom);
        push_hdr(st, st + 12'd2, ALL);
        push_hdr(st + 12'd40, st + 12'd40, ALL);
        wait_done(8, 200);
        chk("t5_rdreq_count", 160'(rdreq_cyc.size()), 160'(2));
        chk("t5_last_count", 160'(last_cyc.size()), 160'(2));
        if (rdreq_cyc.size() >= 2 && last_cyc.size() >= 1) begin
            chk("t5_gap", 160'(rdreq_cyc[1]), 160'(last_cyc[0] + 1));
        end
        compare_stream("t5");

        // Reset after 3 samples of an 8-sample event
        push_hdr(12'h200, 12'h207, 3);
        begin
            int i;
            i = 0;
            while (!dout_valid && i < 20) begin
                step();
                i++;
            end
        end
        chk("t6_start", 160'(dout_valid), 160'(1));
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("t6_reset_outputs",
            160'({hdr_rdreq, wvb_rden, wvb_rd_addr, hdr_valid, dout, dout_valid,
                  dout_last, rd_ptr, busy, evt_cnt}), 160'(0));
        chk("t6_reset_fields",
            160'({evt_ltc, evt_len, evt_trig_src, evt_cnst_run, evt_pre_conf}), 160'(0));
        rst = 1'b0;
        compare_stream("t6_partial");
        push_hdr(12'h300, 12'h305, ALL);
        wait_done(1, 100);
        chk("t6_rd_ptr", 160'(rd_ptr), 160'(12'h306));
        compare_stream("t6_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wvb_rd_ctrl.md
# wvb_rd_ctrl

Waveform buffer read controller for one mDOM channel. It sits directly downstream of the waveform buffer write controller. It pops event headers from the header FIFO, reads the event's samples from the waveform buffer RAM, and streams the header and the samples to the readout arbiter over valid/ready handshakes. It also publishes a read pointer so upstream overflow logic knows which buffer space is free.

## Interface
Parameters:
- P_DATA_WIDTH, 22, sample word width (waveform RAM read width)
- P_ADR_WIDTH, 12, waveform RAM address width
- P_HDR_WIDTH, 80, header FIFO word width
- P_LTC_WIDTH, 48, event timestamp width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- hdr_empty  in  1  header FIFO empty (standard FIFO, 1-cycle read latency)
- hdr_rdreq  out  1  header FIFO read request, single-cycle pulse
- hdr_data  in  P_HDR_WIDTH  FIFO word: [47:0] ltc, [59:48] start_addr, [71:60] stop_addr, [73:72] trig_src, [74] cnst_run, [79:75] pre_conf
- wvb_rd_addr  out  P_ADR_WIDTH  waveform RAM read address
- wvb_rden  out  1  waveform RAM read enable; data valid 1 cycle later
- wvb_data  in  P_DATA_WIDTH  waveform RAM read data
- evt_ltc  out  P_LTC_WIDTH  latched event timestamp
- evt_len  out  P_ADR_WIDTH+1  sample count of the event
- evt_trig_src  out  2  latched trigger source
- evt_cnst_run  out  1  latched constant-run flag
- evt_pre_conf  out  5  latched pretrigger config
- hdr_valid  out  1  evt_* fields valid
- hdr_ready  in  1  downstream accepts the header
- dout  out  P_DATA_WIDTH  sample data
- dout_valid  out  1  dout valid
- dout_last  out  1  asserted together with the final sample of the event
- dout_ready  in  1  downstream accepts the sample
- rd_ptr  out  P_ADR_WIDTH  address following the last sample accepted downstream
- busy  out  1  state is not S_IDLE
- evt_cnt  out  16  count of completed events; wraps

## Operation
- FSM states: S_IDLE, S_HDR_WAIT, S_HDR, S_DATA.
- S_IDLE: if !hdr_empty, assert hdr_rdreq for one cycle and go to S_HDR_WAIT.
- S_HDR_WAIT: latch all hdr_data fields into evt_*. Compute evt_len = ((stop_addr − start_addr) mod 2^P_ADR_WIDTH) + 1, giving a range of 1..2^P_ADR_WIDTH. Load the read address with start_addr and the remaining count with evt_len. Go to S_HDR.
- S_HDR: hold hdr_valid=1 until hdr_ready. On the handshake, drop hdr_valid and go to S_DATA.
- S_DATA: issue reads in order from start_addr. The address increments mod 2^P_ADR_WIDTH, so it wraps from all-ones to 0. Reads stop when the remaining count reaches 0.
- Output buffering: a 2-entry output buffer (output register plus skid) absorbs the 1-cycle RAM latency under backpressure.
- Read issue rule: issue a read when remaining>0 and (occupied+in-flight)<2, or when (occupied+in-flight)==2 and a dout handshake happens in the same cycle.
- Ordering: no sample is lost, duplicated or reordered under any dout_ready pattern.
- dout_last is asserted with the evt_len-th sample.
- rd_ptr advances by 1 (mod 2^P_ADR_WIDTH) on each dout handshake.
- Event completion: on the handshake of the last sample, increment evt_cnt and return to S_IDLE.
- hdr_rdreq is only ever asserted in S_IDLE with hdr_empty=0.
- evt_* fields hold their values until the next S_HDR_WAIT.

## Timing
- Reset values: every output is 0 (hdr_rdreq, wvb_rden, wvb_rd_addr, evt_*, hdr_valid, dout, dout_valid, dout_last, rd_ptr, busy, evt_cnt). FSM resets to S_IDLE and the internal buffer is emptied.
- Header path: hdr_empty falls while the FSM is in S_IDLE at cycle t.
  - hdr_rdreq is asserted at t.
  - Fields are latched at t+1.
  - hdr_valid is asserted at t+2.
- Data path: header handshake at cycle h.
  - First wvb_rden at h+1.
  - First dout_valid at h+2.
  - With dout_ready held at 1, one sample per cycle; the last sample is at h+1+evt_len.
- Event-to-event gap: the FSM is back in S_IDLE one cycle after the last-sample handshake. The next hdr_rdreq may occur in that same cycle.
- Reset mid-event: in-flight reads are discarded and no further hdr_rdreq is issued. The popped header is lost; recovery is the system's responsibility, and the writer is reset together with this block.
- Simultaneous events: hdr_empty is not sampled outside S_IDLE. A handshake and a refill of the buffer in the same cycle are legal.

## Test plan
- Single event, start=0x010, stop=0x014, RAM[a]=a, ready=1 -> evt_len=5; dout sequence 0x010..0x014; dout_last on 0x014; rd_ptr=0x015; evt_cnt=1.
- Wrap-around, start=0xFFE, stop=0x001 -> evt_len=4; addresses 0xFFE, 0xFFF, 0x000, 0x001; rd_ptr=0x002.
- Full buffer, start=0x100, stop=0x0FF -> evt_len=4096; 4096 samples; dout_last only on address 0x0FF.
- Random dout_ready (50%) and random hdr_ready stalls over 3 events -> sample stream matches the reference model exactly (no loss, duplicate or reorder); dout holds stable while valid && !ready.
- Two headers queued back to back, lengths 3 and 1 -> second hdr_rdreq occurs in the first S_IDLE cycle after the first event's last handshake; a 1-sample event has dout_last on its only sample.
- rst asserted during S_DATA of an 8-sample event after 3 samples -> next cycle all outputs are 0 and the FSM is in S_IDLE; a new event after reset streams correctly from its start_addr.
